fsqrt_seq: RTL

FSQRT_SEQ -- requirements
Module: fsqrt_seq

---
 rtl/fsqrt_seq_if.sv | 31 +++
 rtl/fsqrt_seq.sv | 119 +++++++++++
 2 files changed

// File: rtl/fsqrt_seq_if.sv
// Request/unit/response bundle for the square-root sequencer.
// slave = sequencer side, master = requester + unit + consumer side.
interface fsqrt_seq_if #(
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_x;
    logic [TAG_W-1:0] req_tag;

    logic             unit_start;
    logic [31:0]      unit_x;
    logic [31:0]      unit_y;
    logic             unit_valid;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_y;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;

    modport slave (
        input  req_valid, req_x, req_tag, unit_y, unit_valid, rsp_ready,
        output req_ready, unit_start, unit_x, rsp_valid, rsp_y, rsp_tag, rsp_err
    );

    modport master (
        output req_valid, req_x, req_tag, unit_y, unit_valid, rsp_ready,
        input  req_ready, unit_start, unit_x, rsp_valid, rsp_y, rsp_tag, rsp_err
    );
endinterface

// File: rtl/fsqrt_seq.sv
// Single-outstanding sqrt sequencer: specials answered in 1 cycle, unit results after start + unit latency + 1,
// abort with qNaN after TIMEOUT WAIT cycles; result held until rsp_ready, req_ready only while idle.
module fsqrt_seq #(
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    fsqrt_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;

    localparam logic [31:0] QNAN  = 32'h7FC0_0000;
    localparam logic [31:0] P_INF = 32'h7F80_0000;
    localparam int          CNT_W = $clog2(TIMEOUT + 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      x_q;
    logic [31:0]      y_q;
    logic [TAG_W-1:0] tag_q;
    logic             err_q;

    logic             accept;
    logic             is_special;
    logic [31:0]      special_y;
    logic             timeout_hit;

    assign accept      = bus.req_valid && (state == IDLE);
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

    // Operands whose root is fixed by IEEE rules never reach the unit.
    always_comb begin
        is_special = 1'b1;
        special_y  = QNAN;
        if (bus.req_x[30:23] == 8'hFF && bus.req_x[22:0] != 23'd0) begin
            special_y = QNAN;
        end else if (bus.req_x[30:0] == 31'd0) begin
            special_y = bus.req_x;
        end else if (bus.req_x[31]) begin
            special_y = QNAN;
        end else if (bus.req_x == P_INF) begin
            special_y = P_INF;
        end else begin
            is_special = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = is_special ? HOLD : LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    if (bus.unit_valid || timeout_hit) state_nxt = HOLD;
            HOLD:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state == IDLE);
        bus.unit_start = (state == LAUNCH);
        bus.rsp_valid  = (state == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            x_q      <= '0;
            y_q      <= '0;
            tag_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        x_q   <= bus.req_x;
                        tag_q <= bus.req_tag;
                        if (is_special) begin
                            y_q   <= special_y;
                            err_q <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    // A result arriving in the last allowed cycle beats the abort.
                    if (bus.unit_valid) begin
                        y_q   <= bus.unit_y;
                        err_q <= 1'b0;
                    end else if (timeout_hit) begin
                        y_q   <= QNAN;
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.unit_x  = x_q;
    assign bus.rsp_y   = y_q;
    assign bus.rsp_tag = tag_q;
    assign bus.rsp_err = err_q;
endmodule
